// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: on a CPU write to the DMA register it halts the CPU and
// copies one 256-byte page to the OAM data port, one byte every five cycles.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_bus_addr,
    input  logic [7:0]  cpu_bus_data_out,
    input  logic        cpu_bus_write_en,
    input  logic [7:0]  cpu_bus_data_in,
    input  logic        cpu_is_halted,
    input  logic        dbg_halt,
    output logic        dma_halt,
    output logic        dma_bus_own,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_read_en,
    output logic        dma_write_en,
    output logic        dma_busy,
    output logic        dma_done
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HALT_WAIT = 4'd1,
        S_ARB       = 4'd2,
        S_RD        = 4'd3,
        S_RD_WAIT   = 4'd4,
        S_RD_CAP    = 4'd5,
        S_WR        = 4'd6,
        S_DONE      = 4'd7
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        trigger;

    assign trigger = cpu_bus_write_en && (cpu_bus_addr == DMA_REG_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            page_q  <= 8'd0;
            idx_q   <= 8'd0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    page_d  = cpu_bus_data_out;
                    idx_d   = 8'd0;
                    state_d = S_HALT_WAIT;
                end
            end
            S_HALT_WAIT: begin
                if (cpu_is_halted) state_d = S_ARB;
            end
            // The debugger gets first claim on the bus between bytes.
            S_ARB: begin
                if (!dbg_halt) state_d = S_RD;
            end
            S_RD:      state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_RD_CAP;
            S_RD_CAP: begin
                wdata_d = cpu_bus_data_in;
                state_d = S_WR;
            end
            S_WR: begin
                if (idx_q == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_ARB;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                page_d  = 8'd0;
                idx_d   = 8'd0;
                wdata_d = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the state alone so an unknown state reads as idle.
    always_comb begin
        dma_halt     = 1'b0;
        dma_bus_own  = 1'b0;
        dma_addr     = 16'h0000;
        dma_wdata    = 8'h00;
        dma_read_en  = 1'b0;
        dma_write_en = 1'b0;
        dma_busy     = 1'b0;
        dma_done     = 1'b0;
        case (state_q)
            S_HALT_WAIT, S_ARB: begin
                dma_halt = 1'b1;
                dma_busy = 1'b1;
            end
            S_RD: begin
                dma_halt    = 1'b1;
                dma_busy    = 1'b1;
                dma_bus_own = 1'b1;
                dma_addr    = {page_q, idx_q};
                dma_read_en = 1'b1;
            end
            S_RD_WAIT, S_RD_CAP: begin
                dma_halt    = 1'b1;
                dma_busy    = 1'b1;
                dma_bus_own = 1'b1;
            end
            S_WR: begin
                dma_halt     = 1'b1;
                dma_busy     = 1'b1;
                dma_bus_own  = 1'b1;
                dma_addr     = OAM_DATA_ADDR;
                dma_wdata    = wdata_q;
                dma_write_en = 1'b1;
            end
            S_DONE: dma_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: each trigger queues the 256 expected reads,
// writes and the completion; a negedge monitor pops and compares.
module tb_oam_dma_ctrl;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA = 16'h2004;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_bus_addr = 16'h0000;
    logic [7:0]  cpu_bus_data_out = 8'h00;
    logic        cpu_bus_write_en = 1'b0;
    logic [7:0]  cpu_bus_data_in = 8'h00;
    logic        cpu_is_halted = 1'b0;
    logic        dbg_manual = 1'b0;
    logic        dbg_rand = 1'b0;
    logic        rand_en = 1'b0;
    logic        dbg_halt;
    logic        dma_halt, dma_bus_own, dma_read_en, dma_write_en, dma_busy, dma_done;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit halted_ok = 1'b0;

    logic [15:0] exp_rd_q[$];
    logic [7:0]  exp_wr_q[$];
    int          exp_done_q[$];

    assign dbg_halt = dbg_manual | dbg_rand;

    oam_dma_ctrl #(.DMA_REG_ADDR(DMA_REG), .OAM_DATA_ADDR(OAM_DATA)) dut (
        .clk(clk), .rst(rst),
        .cpu_bus_addr(cpu_bus_addr), .cpu_bus_data_out(cpu_bus_data_out),
        .cpu_bus_write_en(cpu_bus_write_en), .cpu_bus_data_in(cpu_bus_data_in),
        .cpu_is_halted(cpu_is_halted), .dbg_halt(dbg_halt),
        .dma_halt(dma_halt), .dma_bus_own(dma_bus_own), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_read_en(dma_read_en), .dma_write_en(dma_write_en),
        .dma_busy(dma_busy), .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Page 2 holds i^5A; other pages are additionally tagged with page^2.
    function automatic logic [7:0] memData(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'h02);
    endfunction

    always @(posedge clk) begin
        if (dma_read_en) cpu_bus_data_in <= memData(dma_addr);
    end

    always @(negedge clk) begin
        dbg_rand <= rand_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every bus access and completion is matched against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (dma_read_en || dma_write_en) begin
                checkOutput("strobe_exclusive", 32'(dma_read_en & dma_write_en), 0);
                checkOutput("strobe_needs_own", 32'(dma_bus_own), 1);
            end
            if (dma_read_en) begin
                checkOutput("read_pending", 32'(exp_rd_q.size() != 0), 1);
                checkOutput("read_after_halt", 32'(halted_ok), 1);
                if (exp_rd_q.size() != 0) checkOutput("read_addr", 32'(dma_addr), 32'(exp_rd_q.pop_front()));
            end
            if (dma_write_en) begin
                checkOutput("write_pending", 32'(exp_wr_q.size() != 0), 1);
                checkOutput("write_addr", 32'(dma_addr), 32'(OAM_DATA));
                if (exp_wr_q.size() != 0) checkOutput("write_data", 32'(dma_wdata), 32'(exp_wr_q.pop_front()));
            end
            if (dma_done) begin
                checkOutput("done_pending", 32'(exp_done_q.size() != 0), 1);
                checkOutput("done_all_bytes", 32'(exp_wr_q.size()), 0);
                if (exp_done_q.size() != 0) begin
                    int t;
                    t = exp_done_q.pop_front();
                    if (t >= 0) checkOutput("done_cycle", 32'(cyc), 32'(t));
                end
                checkOutput("done_halt", 32'(dma_halt), 0);
                checkOutput("done_own", 32'(dma_bus_own), 0);
                checkOutput("done_busy", 32'(dma_busy), 0);
            end else begin
                checkOutput("busy", 32'(dma_busy), 32'(exp_done_q.size() != 0));
                checkOutput("halt_req", 32'(dma_halt), 32'(exp_done_q.size() != 0));
            end
        end
    end

    // Trigger one transfer; the completion is expected in the 1282nd cycle after
    // the trigger edge (one HALT_WAIT cycle, 256*5 byte cycles, then DONE).
    task automatic applyStimulus(input logic [7:0] page, input int halt_delay, input bit timed);
        @(negedge clk);
        cpu_bus_addr     = DMA_REG;
        cpu_bus_data_out = page;
        cpu_bus_write_en = 1'b1;
        @(posedge clk);
        #1;
        cpu_bus_write_en = 1'b0;
        cpu_bus_addr     = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            exp_rd_q.push_back({page, 8'(i)});
            exp_wr_q.push_back(memData({page, 8'(i)}));
        end
        exp_done_q.push_back(timed ? cyc + 1281 : -1);
        halted_ok = cpu_is_halted;
        if (!cpu_is_halted) begin
            repeat (halt_delay) @(negedge clk);
            #1;
            cpu_is_halted = 1'b1;
            halted_ok     = 1'b1;
        end
    endtask

    task automatic waitForRead(input logic [7:0] idx);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(negedge clk);
            if (dma_read_en && dma_addr[7:0] == idx) found = 1'b1;
        end
        checkOutput("reached_byte", 32'(found), 1);
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 5000 && exp_done_q.size() != 0; n++) @(negedge clk);
        checkOutput("transfer_completes", 32'(exp_done_q.size()), 0);
        checkOutput("reads_consumed", 32'(exp_rd_q.size()), 0);
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_done_q.delete();
        cpu_is_halted = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_halt"}, 32'(dma_halt), 0);
        checkOutput({tag, "_own"}, 32'(dma_bus_own), 0);
        checkOutput({tag, "_busy"}, 32'(dma_busy), 0);
        checkOutput({tag, "_done"}, 32'(dma_done), 0);
        checkOutput({tag, "_strobes"}, 32'({dma_read_en, dma_write_en}), 0);
        checkOutput({tag, "_addr"}, 32'(dma_addr), 0);
        checkOutput({tag, "_wdata"}, 32'(dma_wdata), 0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL global_timeout: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("idle");

        // Page 2, CPU acknowledges 3 cycles late and drops its ack midway.
        applyStimulus(8'h02, 3, 1'b0);
        waitForRead(8'd128);
        cpu_is_halted = 1'b0;
        waitIdle();

        // Already halted at trigger: exact completion cycle.
        cpu_is_halted = 1'b1;
        applyStimulus(8'h02, 0, 1'b1);
        waitIdle();

        // Debug pause of 20 cycles right after byte 10.
        applyStimulus(8'($urandom_range(0, 255)), 1, 1'b0);
        waitForRead(8'd10);
        repeat (3) @(negedge clk);
        checkOutput("pause_in_wr", 32'(dma_write_en), 1);
        dbg_manual = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            checkOutput("pause_own", 32'(dma_bus_own), 0);
            checkOutput("pause_halt", 32'(dma_halt), 1);
        end
        dbg_manual = 1'b0;
        waitIdle();

        // Retrigger with page 7 mid-transfer must be ignored.
        applyStimulus(8'h02, 2, 1'b0);
        waitForRead(8'd40);
        cpu_bus_addr     = DMA_REG;
        cpu_bus_data_out = 8'h07;
        cpu_bus_write_en = 1'b1;
        @(negedge clk);
        cpu_bus_write_en = 1'b0;
        cpu_bus_addr     = 16'h0000;
        waitIdle();

        // Reset at byte 100 aborts with no completion pulse.
        applyStimulus(8'($urandom_range(0, 255)), 1, 1'b0);
        waitForRead(8'd100);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("abort");
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_done_q.delete();
        cpu_is_halted = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("abort_hold");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(8'h02, 2, 1'b0);
        waitIdle();

        // Top page must not carry into 16'h0000.
        applyStimulus(8'hFF, 1, 1'b0);
        waitIdle();

        // Random pages, acknowledge delays and debug pauses.
        rand_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 5), 1'b0);
            waitIdle();
        end
        rand_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
